jtag_tap_responder: RTL and testbench

Synthesizable JTAG TAP target that answers the host-side JTAG driver (`TCK`/`TMS`/`TDI`/`TRSTn` in, `TDO` out) entirely inside the system clock domain. TCK is oversampled and edge-detected rather than used as a clock. The block implements the IEEE 1149.1 16-state TAP controller with a 5-bit IR and three data registers: IDCODE, BYPASS and a user data register. It gives the SoC a JTAG-reachable mailbox with no second clock domain, and serves as a loopback target for the JTAG bring-up bench.

---
 rtl/jtag_tap_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_responder.sv
// JTAG TAP target running entirely in the system clock domain.
// TCK is oversampled and edge-detected; IR plus IDCODE, BYPASS and user DR.
module jtag_tap_responder #(
  parameter int unsigned         IR_WIDTH      = 5,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h0000_0001,
  parameter int unsigned         USER_DR_WIDTH = 32,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE     = IR_WIDTH'(5'h01),
  parameter logic [IR_WIDTH-1:0] IR_USER       = IR_WIDTH'(5'h10)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     tck,
  input  logic                     tms,
  input  logic                     tdi,
  input  logic                     trstn,
  output logic                     tdo,
  output logic                     tdo_oe,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_dr_update,
  output logic [3:0]               tap_state
);

  localparam int unsigned IDCODE_WIDTH = 32;

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SH_DR    = 4'd4,
    EX1_DR   = 4'd5,
    PAUSE_DR = 4'd6,
    EX2_DR   = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SH_IR    = 4'd11,
    EX1_IR   = 4'd12,
    PAUSE_IR = 4'd13,
    EX2_IR   = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_t;

  // Synchronizer flops; the third tck stage is the edge-detect reference.
  logic tck_meta, tck_sync, tck_prev;
  logic tms_meta, tms_sync;
  logic tdi_meta, tdi_sync;
  logic trstn_meta, trstn_sync;

  logic tck_rise;
  logic tck_fall;

  tap_state_t state_q;
  tap_state_t state_d;

  logic [IR_WIDTH-1:0]      ir;
  logic [IR_WIDTH-1:0]      ir_sr;
  logic [IDCODE_WIDTH-1:0]  idcode_sr;
  logic                     bypass_sr;
  logic [USER_DR_WIDTH-1:0] user_sr;

  logic cap_ir, sh_ir, upd_ir;
  logic cap_dr, sh_dr, upd_dr;
  logic sel_idcode, sel_user;
  logic dr_bit0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tck_meta   <= 1'b0;
      tck_sync   <= 1'b0;
      tck_prev   <= 1'b0;
      tms_meta   <= 1'b0;
      tms_sync   <= 1'b0;
      tdi_meta   <= 1'b0;
      tdi_sync   <= 1'b0;
      trstn_meta <= 1'b1;
      trstn_sync <= 1'b1;
    end else begin
      tck_meta   <= tck;
      tck_sync   <= tck_meta;
      tck_prev   <= tck_sync;
      tms_meta   <= tms;
      tms_sync   <= tms_meta;
      tdi_meta   <= tdi;
      tdi_sync   <= tdi_meta;
      trstn_meta <= trstn;
      trstn_sync <= trstn_meta;
    end
  end

  assign tck_rise = tck_sync & ~tck_prev;
  assign tck_fall = ~tck_sync & tck_prev;

  // Instruction decode: every opcode other than IDCODE/USER selects BYPASS.
  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_user   = (ir == IR_USER);

  always_comb begin
    dr_bit0 = bypass_sr;
    if (sel_idcode) begin
      dr_bit0 = idcode_sr[0];
    end else if (sel_user) begin
      dr_bit0 = user_sr[0];
    end
  end

  // TAP state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the per-state action strobes fired on the exiting TCK rise.
  always_comb begin
    state_d = state_q;
    cap_ir  = 1'b0;
    sh_ir   = 1'b0;
    upd_ir  = 1'b0;
    cap_dr  = 1'b0;
    sh_dr   = 1'b0;
    upd_dr  = 1'b0;
    if (!trstn_sync) begin
      state_d = TLR;
    end else if (tck_rise) begin
      unique case (state_q)
        TLR:      state_d = tms_sync ? TLR    : RTI;
        RTI:      state_d = tms_sync ? SEL_DR : RTI;
        SEL_DR:   state_d = tms_sync ? SEL_IR : CAP_DR;
        CAP_DR: begin
          cap_dr  = 1'b1;
          state_d = tms_sync ? EX1_DR : SH_DR;
        end
        SH_DR: begin
          sh_dr   = 1'b1;
          state_d = tms_sync ? EX1_DR : SH_DR;
        end
        EX1_DR:   state_d = tms_sync ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_d = tms_sync ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_d = tms_sync ? UPD_DR : SH_DR;
        UPD_DR: begin
          upd_dr  = 1'b1;
          state_d = tms_sync ? SEL_DR : RTI;
        end
        SEL_IR:   state_d = tms_sync ? TLR    : CAP_IR;
        CAP_IR: begin
          cap_ir  = 1'b1;
          state_d = tms_sync ? EX1_IR : SH_IR;
        end
        SH_IR: begin
          sh_ir   = 1'b1;
          state_d = tms_sync ? EX1_IR : SH_IR;
        end
        EX1_IR:   state_d = tms_sync ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_d = tms_sync ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_d = tms_sync ? UPD_IR : SH_IR;
        UPD_IR: begin
          upd_ir  = 1'b1;
          state_d = tms_sync ? SEL_DR : RTI;
        end
        default:  state_d = TLR;
      endcase
    end
  end

  // IR path.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ir    <= IR_IDCODE;
      ir_sr <= '0;
    end else if (!trstn_sync || state_q == TLR) begin
      ir <= IR_IDCODE;
    end else begin
      if (cap_ir) begin
        ir_sr <= IR_WIDTH'(1);
      end
      if (sh_ir) begin
        ir_sr <= {tdi_sync, ir_sr[IR_WIDTH-1:1]};
      end
      if (upd_ir) begin
        ir <= ir_sr;
      end
    end
  end

  // Data registers; only the one selected by the IR captures or shifts.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      idcode_sr      <= '0;
      bypass_sr      <= 1'b0;
      user_sr        <= '0;
      user_dr_out    <= '0;
      user_dr_update <= 1'b0;
    end else begin
      user_dr_update <= 1'b0;
      if (cap_dr) begin
        if (sel_idcode) begin
          idcode_sr <= IDCODE_VALUE;
        end else if (sel_user) begin
          user_sr <= user_dr_in;
        end else begin
          bypass_sr <= 1'b0;
        end
      end
      if (sh_dr) begin
        if (sel_idcode) begin
          idcode_sr <= {tdi_sync, idcode_sr[IDCODE_WIDTH-1:1]};
        end else if (sel_user) begin
          user_sr <= {tdi_sync, user_sr[USER_DR_WIDTH-1:1]};
        end else begin
          bypass_sr <= tdi_sync;
        end
      end
      if (upd_dr && sel_user) begin
        user_dr_out    <= user_sr;
        user_dr_update <= 1'b1;
      end
    end
  end

  // TDO launches on the TCK fall so it is settled well before the next rise.
  always_ff @(posedge clock) begin
    if (!resetn || !trstn_sync) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else if (tck_fall) begin
      if (state_q == SH_IR) begin
        tdo    <= ir_sr[0];
        tdo_oe <= 1'b1;
      end else if (state_q == SH_DR) begin
        tdo    <= dr_bit0;
        tdo_oe <= 1'b1;
      end else begin
        tdo    <= 1'b0;
        tdo_oe <= 1'b0;
      end
    end
  end

  assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Bench for jtag_tap_responder: directed scenarios plus random JTAG traffic
// checked every TCK against a transaction-level TAP model.
module tb_jtag_tap_responder;

  logic        clock = 1'b0;
  logic        resetn;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        trstn;
  logic        tdo;
  logic        tdo_oe;
  logic [31:0] user_dr_in;
  logic [31:0] user_dr_out;
  logic        user_dr_update;
  logic [3:0]  tap_state;

  jtag_tap_responder dut (
    .clock          (clock),
    .resetn         (resetn),
    .tck            (tck),
    .tms            (tms),
    .tdi            (tdi),
    .trstn          (trstn),
    .tdo            (tdo),
    .tdo_oe         (tdo_oe),
    .user_dr_in     (user_dr_in),
    .user_dr_out    (user_dr_out),
    .user_dr_update (user_dr_update),
    .tap_state      (tap_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;

  // 1149.1 transition table indexed by state, one array per TMS value.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_state;
  logic [4:0]  m_ir;
  logic [4:0]  m_irsr;
  logic [31:0] m_dr;
  int          m_len;
  logic [31:0] m_out;
  int          m_upd = 0;

  always @(posedge clock) begin
    if (user_dr_update === 1'b1) upd_seen++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ir    = 5'h01;
    m_irsr  = 5'h00;
    m_dr    = 32'h0;
    m_len   = 1;
    m_out   = 32'h0;
  endtask

  task automatic model_rise(input bit t_ms, input bit t_di);
    case (m_state)
      3: begin
        if (m_ir == 5'h01) begin
          m_dr = 32'h0000_0001; m_len = 32;
        end else if (m_ir == 5'h10) begin
          m_dr = user_dr_in; m_len = 32;
        end else begin
          m_dr = 32'h0; m_len = 1;
        end
      end
      4: m_dr = (m_dr >> 1) | (32'(t_di) << (m_len - 1));
      8: if (m_ir == 5'h10) begin
        m_out = m_dr;
        m_upd++;
      end
      10: m_irsr = 5'b00001;
      11: m_irsr = (m_irsr >> 1) | (5'(t_di) << 4);
      15: m_ir = m_irsr;
      default: ;
    endcase
    m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
    if (m_state == 0) m_ir = 5'h01;
  endtask

  // One full TCK period; returns the TDO value presented after the fall.
  task automatic tick(input bit t_ms, input bit t_di, output bit t_do);
    bit exp_tdo, exp_oe;
    tms = t_ms;
    tdi = t_di;
    repeat (5) @(negedge clock);
    tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (5) @(negedge clock);
    check_eq("state", 64'(tap_state), 64'(m_state));
    tck = 1'b0;
    repeat (5) @(negedge clock);
    exp_oe  = (m_state == 4) || (m_state == 11);
    exp_tdo = (m_state == 11) ? m_irsr[0] : (m_state == 4) ? m_dr[0] : 1'b0;
    check_eq("tdo", 64'(tdo), 64'(exp_tdo));
    check_eq("tdo_oe", 64'(tdo_oe), 64'(exp_oe));
    check_eq("user_dr_out", 64'(user_dr_out), 64'(m_out));
    check_eq("upd_count", 64'(upd_seen), 64'(m_upd));
    t_do = tdo;
  endtask

  // From RTI: load an IR value, return the captured IR bits, end in RTI.
  task automatic load_ir(input logic [4:0] v, output logic [4:0] cap);
    bit b;
    tick(1, 0, b); tick(1, 0, b); tick(0, 0, b);
    tick(0, 0, b);
    cap[0] = b;
    for (int i = 0; i < 5; i++) begin
      tick(i == 4, v[i], b);
      if (i < 4) cap[i+1] = b;
    end
    tick(1, 0, b); tick(0, 0, b);
  endtask

  // From RTI: shift n DR bits LSB first, return what came out, end in RTI.
  task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    bit b;
    dout = '0;
    tick(1, 0, b); tick(0, 0, b);
    tick(0, 0, b);
    dout[0] = b;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], b);
      if (i < n - 1) dout[i+1] = b;
    end
    tick(1, 0, b); tick(0, 0, b);
  endtask

  task automatic to_rti();
    bit b;
    for (int i = 0; i < 5; i++) tick(1, $urandom_range(0, 1), b);
    tick(0, 0, b);
  endtask

  initial begin
    logic [63:0] dout;
    logic [4:0]  cap;
    bit          b;
    int          upd_before;

    resetn = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0; trstn = 1'b1;
    user_dr_in = 32'h0;
    model_reset();
    repeat (2) @(negedge clock);
    check_eq("rst_state", 64'(tap_state), 64'd0);
    check_eq("rst_tdo_oe", 64'(tdo_oe), 64'd0);
    check_eq("rst_tdo", 64'(tdo), 64'd0);
    check_eq("rst_udo", 64'(user_dr_out), 64'd0);
    check_eq("rst_upd", 64'(user_dr_update), 64'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // IDCODE is the IR after reset.
    tick(0, 0, b);
    shift_dr(32, {$urandom, $urandom}, dout);
    check_eq("idcode_read", dout[31:0], 64'h0000_0001);
    check_eq("idle_oe", 64'(tdo_oe), 64'd0);

    // Load BYPASS, park in ShIR, then escape to TLR with TMS high.
    load_ir(5'h1F, cap);
    tick(1, 0, b); tick(1, 0, b); tick(0, 0, b); tick(0, 0, b);
    check_eq("in_shir", 64'(tap_state), 64'd11);
    for (int i = 0; i < 5; i++) tick(1, 1, b);
    check_eq("tlr_state", 64'(tap_state), 64'd0);
    tick(0, 0, b);
    shift_dr(32, 64'h0, dout);
    check_eq("idcode_after_tlr", dout[31:0], 64'h0000_0001);

    load_ir(5'h1F, cap);
    check_eq("ir_capture", 64'(cap), 64'h01);
    shift_dr(4, 64'b1101, dout);
    check_eq("bypass", dout[3:0], 64'b1010);

    load_ir(5'h10, cap);
    user_dr_in = 32'hCAFE_F00D;
    upd_before = upd_seen;
    shift_dr(32, 64'hDEAD_BEEF, dout);
    check_eq("user_capture", dout[31:0], 64'hCAFE_F00D);
    check_eq("user_out", 64'(user_dr_out), 64'hDEAD_BEEF);
    check_eq("user_pulses", 64'(upd_seen - upd_before), 64'd1);

    // TRSTn mid user shift.
    user_dr_in = $urandom;
    upd_before = upd_seen;
    tick(1, 0, b); tick(0, 0, b); tick(0, 0, b);
    for (int i = 0; i < 10; i++) tick(0, $urandom_range(0, 1), b);
    trstn = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("trst_state", 64'(tap_state), 64'd0);
    check_eq("trst_oe", 64'(tdo_oe), 64'd0);
    m_state = 0; m_ir = 5'h01;
    repeat (3) @(negedge clock);
    check_eq("trst_udo", 64'(user_dr_out), 64'hDEAD_BEEF);
    check_eq("trst_pulses", 64'(upd_seen - upd_before), 64'd0);
    trstn = 1'b1;
    repeat (4) @(negedge clock);
    tick(0, 0, b);
    shift_dr(32, 64'h0, dout);
    check_eq("idcode_after_trst", dout[31:0], 64'h0000_0001);

    // resetn mid user shift.
    load_ir(5'h10, cap);
    upd_before = upd_seen;
    tick(1, 0, b); tick(0, 0, b); tick(0, 0, b);
    for (int i = 0; i < 7; i++) tick(0, $urandom_range(0, 1), b);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst2_state", 64'(tap_state), 64'd0);
    check_eq("rst2_tdo", 64'(tdo), 64'd0);
    check_eq("rst2_oe", 64'(tdo_oe), 64'd0);
    check_eq("rst2_udo", 64'(user_dr_out), 64'd0);
    check_eq("rst2_upd", 64'(user_dr_update), 64'd0);
    check_eq("rst2_pulses", 64'(upd_seen - upd_before), 64'd0);
    model_reset();
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    tick(0, 0, b);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      logic [4:0] v;
      user_dr_in = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 3))
            0: v = 5'h01;
            1: v = 5'h10;
            2: v = 5'h1F;
            default: v = 5'($urandom);
          endcase
          load_ir(v, cap);
        end
        1: shift_dr($urandom_range(1, 36), {$urandom, $urandom}, dout);
        2: begin
          for (int i = 0; i < 8; i++) tick($urandom_range(0, 1), $urandom_range(0, 1), b);
          to_rti();
        end
        default: begin
          load_ir(5'h10, cap);
          shift_dr(32, {$urandom, $urandom}, dout);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
